// File: rtl/ms_fpu_mul_div.sv
// Iterative mantissa multiplier/divider serving the FPU MulDiv request interface.
// Shift-add multiply at CMulBitsPerClk bits per step; restoring divide at 1 bit per step.
module ms_fpu_mul_div #(
  parameter int CMulBitsPerClk = 1
) (
  input  logic        AClkH,
  input  logic        AResetH,
  input  logic        AClkHEn,
  input  logic [31:0] AMulDivDataS,
  input  logic [31:0] AMulDivDataD,
  input  logic [1:0]  AMulDivStart,
  output logic [31:0] AMulDivDataH,
  output logic [31:0] AMulDivDataR,
  output logic        AMulDivWrEn
);

  localparam int MulSteps = 24 / CMulBitsPerClk;
  localparam logic [4:0] MulCntInit = 5'(MulSteps - 1);
  localparam logic [4:0] DivCntInit = 5'd28;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t      state, state_nxt;
  logic [23:0] ms;
  logic [47:0] mcand, prod, partial;
  logic [23:0] mq;
  logic [25:0] rem, two_s, r_sub;
  logic [28:0] quo;
  logic [4:0]  cnt;
  logic        op_div;
  logic        q_bit;

  logic start_mul, start_div, start_any;
  logic load, step_mul, step_div, commit;

  // Operand bits [31:24] carry exponent/sign fields the FPU handles itself.
  logic unused_hi;
  assign unused_hi = ^{AMulDivDataS[31:24], AMulDivDataD[31:24]};

  assign start_mul = AMulDivStart[0];
  assign start_div = (AMulDivStart == 2'b10);
  assign start_any = start_mul | start_div;

  always_ff @(posedge AClkH) begin
    if (AResetH)      state <= IDLE;
    else if (AClkHEn) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (start_any) begin
      state_nxt = start_mul ? MUL : DIV;
    end else begin
      case (state)
        MUL, DIV: if (cnt == 5'd0) state_nxt = DONE;
        DONE:     state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // A new start always wins over any in-flight step or pending commit.
  always_comb begin
    load     = start_any;
    step_mul = (state == MUL)  && !start_any;
    step_div = (state == DIV)  && !start_any;
    commit   = (state == DONE) && !start_any;
  end

  always_comb begin
    partial = '0;
    for (int i = 0; i < CMulBitsPerClk; i++) begin
      if (mq[i]) partial = partial + (mcand << i);
    end
  end

  assign two_s = {1'b0, ms, 1'b0};
  assign q_bit = (rem >= two_s);
  assign r_sub = q_bit ? (rem - two_s) : rem;

  always_ff @(posedge AClkH) begin
    if (AResetH) begin
      ms           <= '0;
      mcand        <= '0;
      mq           <= '0;
      prod         <= '0;
      rem          <= '0;
      quo          <= '0;
      cnt          <= '0;
      op_div       <= 1'b0;
      AMulDivDataR <= '0;
      AMulDivDataH <= '0;
      AMulDivWrEn  <= 1'b0;
    end else if (AClkHEn) begin
      AMulDivWrEn <= commit;
      if (load) begin
        ms     <= AMulDivDataS[23:0];
        mcand  <= {24'h0, AMulDivDataS[23:0]};
        mq     <= AMulDivDataD[23:0];
        prod   <= '0;
        rem    <= {2'b00, AMulDivDataD[23:0]};
        quo    <= '0;
        cnt    <= start_mul ? MulCntInit : DivCntInit;
        op_div <= !start_mul;
      end
      if (step_mul) begin
        prod  <= prod + partial;
        mcand <= mcand << CMulBitsPerClk;
        mq    <= mq >> CMulBitsPerClk;
        cnt   <= cnt - 5'd1;
      end
      if (step_div) begin
        quo <= {quo[27:0], q_bit};
        // Final step leaves rem at twice the true remainder; no shift.
        rem <= (cnt == 5'd0) ? r_sub : {r_sub[24:0], 1'b0};
        cnt <= cnt - 5'd1;
      end
      if (commit) begin
        if (!op_div) begin
          AMulDivDataR <= {3'h0, prod[47:19]};
          AMulDivDataH <= {13'h0, prod[18:0]};
        end else if (ms == 24'h0) begin
          AMulDivDataR <= 32'h1FFF_FFFF;
          AMulDivDataH <= '0;
        end else begin
          AMulDivDataR <= {3'h0, quo};
          AMulDivDataH <= {7'h0, rem[25:1]};
        end
      end
    end
  end

endmodule
